// File: rtl/reorder_buffer_pkg.sv
// Shared widths, slot numbering and store classification for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROBSize      = 16;
  localparam int ROBIdxWidth  = 4;
  localparam int WordWidth    = 32;
  localparam int RegIdxWidth  = 5;
  localparam int InstrIdWidth = 6;

  // Slot 0 is the "no tag" value, so live positions run 1..15.
  localparam logic [ROBIdxWidth-1:0] FirstPos = 4'd1;
  localparam logic [ROBIdxWidth-1:0] LastPos  = 4'd15;

  // Instruction ids of the store family (byte, half, word).
  localparam logic [InstrIdWidth-1:0] StoreIdFirst = 6'd16;
  localparam logic [InstrIdWidth-1:0] StoreIdLast  = 6'd18;

  // Result of an operand lookup: ready flag plus the value when ready.
  typedef struct packed {
    logic                 ready;
    logic [WordWidth-1:0] res;
  } queryResult_t;

  // True when the instruction id belongs to the store family.
  function automatic logic isStore(input logic [InstrIdWidth-1:0] id);
    return (id >= StoreIdFirst) && (id <= StoreIdLast);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at issue, captures CDB results,
// retires the head to the register file / LSB and raises a flush on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,

  output logic                    rob_full_out,
  output logic [ROBIdxWidth-1:0]  rob_free_pos_out,

  input  logic                    issue_to_rob_en_in,
  input  logic [InstrIdWidth-1:0] issue_to_rob_instr_id_in,
  input  logic [RegIdxWidth-1:0]  issue_to_rob_rd_in,
  input  logic [WordWidth-1:0]    issue_to_rob_pc_in,
  input  logic                    issue_to_rob_pred_jump_in,

  input  logic [ROBIdxWidth-1:0]  rob_query1_pos_in,
  input  logic [ROBIdxWidth-1:0]  rob_query2_pos_in,
  output logic                    rob_query1_ready_out,
  output logic [WordWidth-1:0]    rob_query1_res_out,
  output logic                    rob_query2_ready_out,
  output logic [WordWidth-1:0]    rob_query2_res_out,

  input  logic                    cdb_en_in,
  input  logic [ROBIdxWidth-1:0]  cdb_rob_pos_in,
  input  logic [WordWidth-1:0]    cdb_res_in,
  input  logic                    cdb_jump_in,
  input  logic [WordWidth-1:0]    cdb_next_pc_in,

  output logic                    commit_to_regfile_en_out,
  output logic [InstrIdWidth-1:0] commit_to_regfile_instr_id_out,
  output logic [RegIdxWidth-1:0]  commit_to_regfile_rd_out,
  output logic [ROBIdxWidth-1:0]  commit_to_regfile_rob_pos_out,
  output logic [WordWidth-1:0]    commit_to_regfile_res_out,

  output logic                    commit_to_lsb_en_out,
  output logic [ROBIdxWidth-1:0]  commit_to_lsb_rob_pos_out,

  output logic                    clear_branch_out,
  output logic [WordWidth-1:0]    clear_branch_pc_out
);

  // Control state (reset) and entry payload (written only on issue/CDB).
  logic                    r_valid      [ROBSize];
  logic                    r_ready      [ROBSize];
  logic [InstrIdWidth-1:0] r_instrId    [ROBSize];
  logic [RegIdxWidth-1:0]  r_rd         [ROBSize];
  logic [WordWidth-1:0]    r_pc         [ROBSize];
  logic                    r_predJump   [ROBSize];
  logic [WordWidth-1:0]    r_res        [ROBSize];
  logic                    r_mispredict [ROBSize];
  logic [WordWidth-1:0]    r_nextPc     [ROBSize];

  logic [ROBIdxWidth-1:0]  r_head;
  logic [ROBIdxWidth-1:0]  r_tail;
  logic [ROBIdxWidth-1:0]  r_count;

  logic                    w_full;
  logic                    w_issue;
  logic                    w_cdb;
  logic                    w_commit;
  logic                    w_flush;
  logic                    w_unusedPc;
  queryResult_t            w_query1;
  queryResult_t            w_query2;

  // Successor position on the ring, skipping the reserved slot 0.
  function automatic logic [ROBIdxWidth-1:0] nextPos(input logic [ROBIdxWidth-1:0] pos);
    return (pos == LastPos) ? FirstPos : pos + 4'd1;
  endfunction

  // Operand lookup with same-cycle CDB bypass; tag 0 never reports ready.
  function automatic queryResult_t lookup(input logic [ROBIdxWidth-1:0] pos);
    queryResult_t q;
    q.ready = 1'b0;
    q.res   = '0;
    if (pos != '0) begin
      if (cdb_en_in && (cdb_rob_pos_in == pos)) begin
        q.ready = 1'b1;
        q.res   = cdb_res_in;
      end else if (r_valid[pos] && r_ready[pos]) begin
        q.ready = 1'b1;
        q.res   = r_res[pos];
      end
    end
    return q;
  endfunction

  // The cycle after a flush ignores new issue and CDB traffic; a mispredicted
  // commit flushes everything, so the flush takes priority over issue.
  assign w_full     = (r_count == LastPos);
  assign w_commit   = (r_count != '0) && r_valid[r_head] && r_ready[r_head];
  assign w_flush    = w_commit && r_mispredict[r_head];
  assign w_issue    = issue_to_rob_en_in && !w_full && !clear_branch_out && !w_flush;
  assign w_cdb      = cdb_en_in && r_valid[cdb_rob_pos_in] && !clear_branch_out;

  assign rob_full_out     = w_full;
  assign rob_free_pos_out = r_tail;

  // The issuing PC is held per entry for debug visibility only.
  assign w_unusedPc = ^{issue_to_rob_pc_in, r_pc[r_head]};

  // Resolve both operand lookups combinationally.
  always_comb begin
    w_query1 = lookup(rob_query1_pos_in);
    w_query2 = lookup(rob_query2_pos_in);
  end

  assign rob_query1_ready_out = w_query1.ready;
  assign rob_query1_res_out   = w_query1.res;
  assign rob_query2_ready_out = w_query2.ready;
  assign rob_query2_res_out   = w_query2.res;

  // Valid/ready bits and ring pointers: allocate, capture, retire, flush.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROBSize; i++) begin
        r_valid[i] <= 1'b0;
        r_ready[i] <= 1'b0;
      end
      r_head  <= FirstPos;
      r_tail  <= FirstPos;
      r_count <= '0;
    end else if (rdy_in) begin
      if (w_flush) begin
        for (int i = 0; i < ROBSize; i++) begin
          r_valid[i] <= 1'b0;
          r_ready[i] <= 1'b0;
        end
        r_head  <= FirstPos;
        r_tail  <= FirstPos;
        r_count <= '0;
      end else begin
        if (w_cdb) begin
          r_ready[cdb_rob_pos_in] <= 1'b1;
        end
        if (w_commit) begin
          r_valid[r_head] <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= nextPos(r_head);
        end
        if (w_issue) begin
          r_valid[r_tail] <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= nextPos(r_tail);
        end
        if (w_issue && !w_commit) begin
          r_count <= r_count + 4'd1;
        end else if (w_commit && !w_issue) begin
          r_count <= r_count - 4'd1;
        end
      end
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (w_issue) begin
        r_instrId[r_tail]  <= issue_to_rob_instr_id_in;
        r_rd[r_tail]       <= issue_to_rob_rd_in;
        r_pc[r_tail]       <= issue_to_rob_pc_in;
        r_predJump[r_tail] <= issue_to_rob_pred_jump_in;
      end
      if (w_cdb) begin
        r_res[cdb_rob_pos_in]        <= cdb_res_in;
        r_mispredict[cdb_rob_pos_in] <= (cdb_jump_in != r_predJump[cdb_rob_pos_in]);
        r_nextPc[cdb_rob_pos_in]     <= cdb_next_pc_in;
      end
    end
  end

  // Registered retirement pulses toward the register file, LSB and front end.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      commit_to_regfile_en_out       <= 1'b0;
      commit_to_regfile_instr_id_out <= '0;
      commit_to_regfile_rd_out       <= '0;
      commit_to_regfile_rob_pos_out  <= '0;
      commit_to_regfile_res_out      <= '0;
      commit_to_lsb_en_out           <= 1'b0;
      commit_to_lsb_rob_pos_out      <= '0;
      clear_branch_out               <= 1'b0;
      clear_branch_pc_out            <= '0;
    end else if (rdy_in) begin
      commit_to_regfile_en_out <= w_commit;
      commit_to_lsb_en_out     <= w_commit && isStore(r_instrId[r_head]);
      clear_branch_out         <= w_flush;
      if (w_commit) begin
        commit_to_regfile_instr_id_out <= r_instrId[r_head];
        commit_to_regfile_rd_out       <= r_rd[r_head];
        commit_to_regfile_rob_pos_out  <= r_head;
        commit_to_regfile_res_out      <= r_res[r_head];
        commit_to_lsb_rob_pos_out      <= r_head;
      end
      if (w_flush) begin
        clear_branch_pc_out <= r_nextPc[r_head];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with an in-order commit scoreboard.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_full_out;
  logic [3:0]  rob_free_pos_out;
  logic        issue_to_rob_en_in;
  logic [5:0]  issue_to_rob_instr_id_in;
  logic [4:0]  issue_to_rob_rd_in;
  logic [31:0] issue_to_rob_pc_in;
  logic        issue_to_rob_pred_jump_in;
  logic [3:0]  rob_query1_pos_in;
  logic [3:0]  rob_query2_pos_in;
  logic        rob_query1_ready_out;
  logic [31:0] rob_query1_res_out;
  logic        rob_query2_ready_out;
  logic [31:0] rob_query2_res_out;
  logic        cdb_en_in;
  logic [3:0]  cdb_rob_pos_in;
  logic [31:0] cdb_res_in;
  logic        cdb_jump_in;
  logic [31:0] cdb_next_pc_in;
  logic        commit_to_regfile_en_out;
  logic [5:0]  commit_to_regfile_instr_id_out;
  logic [4:0]  commit_to_regfile_rd_out;
  logic [3:0]  commit_to_regfile_rob_pos_out;
  logic [31:0] commit_to_regfile_res_out;
  logic        commit_to_lsb_en_out;
  logic [3:0]  commit_to_lsb_rob_pos_out;
  logic        clear_branch_out;
  logic [31:0] clear_branch_pc_out;

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  // Scoreboard: program-order positions plus per-slot expectations.
  int unsigned expQ [$];
  logic [5:0]  expId    [16];
  logic [4:0]  expRd    [16];
  logic        expPred  [16];
  logic [31:0] expRes   [16];
  logic        expMisp  [16];
  logic [31:0] expNpc   [16];
  logic        expStore [16];
  logic [3:0]  mTail;

  reorder_buffer dut (
    .clk_in                         (clk_in),
    .rst_in                         (rst_in),
    .rdy_in                         (rdy_in),
    .rob_full_out                   (rob_full_out),
    .rob_free_pos_out               (rob_free_pos_out),
    .issue_to_rob_en_in             (issue_to_rob_en_in),
    .issue_to_rob_instr_id_in       (issue_to_rob_instr_id_in),
    .issue_to_rob_rd_in             (issue_to_rob_rd_in),
    .issue_to_rob_pc_in             (issue_to_rob_pc_in),
    .issue_to_rob_pred_jump_in      (issue_to_rob_pred_jump_in),
    .rob_query1_pos_in              (rob_query1_pos_in),
    .rob_query2_pos_in              (rob_query2_pos_in),
    .rob_query1_ready_out           (rob_query1_ready_out),
    .rob_query1_res_out             (rob_query1_res_out),
    .rob_query2_ready_out           (rob_query2_ready_out),
    .rob_query2_res_out             (rob_query2_res_out),
    .cdb_en_in                      (cdb_en_in),
    .cdb_rob_pos_in                 (cdb_rob_pos_in),
    .cdb_res_in                     (cdb_res_in),
    .cdb_jump_in                    (cdb_jump_in),
    .cdb_next_pc_in                 (cdb_next_pc_in),
    .commit_to_regfile_en_out       (commit_to_regfile_en_out),
    .commit_to_regfile_instr_id_out (commit_to_regfile_instr_id_out),
    .commit_to_regfile_rd_out       (commit_to_regfile_rd_out),
    .commit_to_regfile_rob_pos_out  (commit_to_regfile_rob_pos_out),
    .commit_to_regfile_res_out      (commit_to_regfile_res_out),
    .commit_to_lsb_en_out           (commit_to_lsb_en_out),
    .commit_to_lsb_rob_pos_out      (commit_to_lsb_rob_pos_out),
    .clear_branch_out               (clear_branch_out),
    .clear_branch_pc_out            (clear_branch_pc_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [3:0] modelNext(input logic [3:0] p);
    return (p == 4'd15) ? 4'd1 : p + 4'd1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One cycle of issue and/or CDB traffic; accepted issues go into the scoreboard.
  task automatic applyStimulus(input bit issueEn, input bit expectAccept, input logic [5:0] id,
                               input logic [4:0] rd, input bit pred, input bit cdbEn,
                               input logic [3:0] pos, input logic [31:0] res, input bit jump,
                               input logic [31:0] npc);
    if (issueEn && expectAccept) checkOutput("issueTag", {28'd0, rob_free_pos_out}, {28'd0, mTail});
    issue_to_rob_en_in        = issueEn;
    issue_to_rob_instr_id_in  = id;
    issue_to_rob_rd_in        = rd;
    issue_to_rob_pc_in        = 32'h1000 + {27'd0, rd, 2'b00};
    issue_to_rob_pred_jump_in = pred;
    cdb_en_in                 = cdbEn;
    cdb_rob_pos_in            = pos;
    cdb_res_in                = res;
    cdb_jump_in               = jump;
    cdb_next_pc_in            = npc;
    if (issueEn && expectAccept) begin
      expId[mTail]    = id;
      expRd[mTail]    = rd;
      expPred[mTail]  = pred;
      expStore[mTail] = (id >= 6'd16) && (id <= 6'd18);
      expQ.push_back(int'(mTail));
      mTail = modelNext(mTail);
    end
    if (cdbEn) begin
      expRes[pos]  = res;
      expMisp[pos] = (jump != expPred[pos]);
      expNpc[pos]  = npc;
    end
    tick();
    issue_to_rob_en_in = 1'b0;
    cdb_en_in          = 1'b0;
  endtask

  task automatic issueOp(input logic [5:0] id, input logic [4:0] rd, input bit pred, input bit accept);
    applyStimulus(1'b1, accept, id, rd, pred, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic cdbOp(input logic [3:0] pos, input logic [31:0] res, input bit jump, input logic [31:0] npc);
    applyStimulus(1'b0, 1'b0, 6'd0, 5'd0, 1'b0, 1'b1, pos, res, jump, npc);
  endtask

  task automatic waitDrain(input int maxCycles);
    for (int i = 0; i < maxCycles && expQ.size() != 0; i++) tick();
    checkOutput("drainDone", expQ.size(), 32'd0);
  endtask

  // Commit monitor: every pulse must match the oldest outstanding entry.
  always @(negedge clk_in) begin
    if (!rst_in && commit_to_regfile_en_out) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedCommit", 32'd1, 32'd0);
      end else begin
        automatic int unsigned p = expQ.pop_front();
        checkOutput("commitPos", {28'd0, commit_to_regfile_rob_pos_out}, p);
        checkOutput("commitId", {26'd0, commit_to_regfile_instr_id_out}, {26'd0, expId[p]});
        checkOutput("commitRd", {27'd0, commit_to_regfile_rd_out}, {27'd0, expRd[p]});
        checkOutput("commitRes", commit_to_regfile_res_out, expRes[p]);
        checkOutput("lsbEn", {31'd0, commit_to_lsb_en_out}, {31'd0, expStore[p]});
        if (expStore[p]) checkOutput("lsbPos", {28'd0, commit_to_lsb_rob_pos_out}, p);
        checkOutput("clearBranch", {31'd0, clear_branch_out}, {31'd0, expMisp[p]});
        if (expMisp[p]) begin
          checkOutput("clearPc", clear_branch_pc_out, expNpc[p]);
          expQ.delete();
        end
      end
    end
  end

  initial begin
    automatic int unsigned cdbOrder [14] = '{2, 1, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 4, 3};
    automatic bit seen;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    issue_to_rob_en_in = 1'b0;
    issue_to_rob_instr_id_in = '0;
    issue_to_rob_rd_in = '0;
    issue_to_rob_pc_in = '0;
    issue_to_rob_pred_jump_in = 1'b0;
    rob_query1_pos_in = 4'd1;
    rob_query2_pos_in = 4'd0;
    cdb_en_in = 1'b0;
    cdb_rob_pos_in = '0;
    cdb_res_in = '0;
    cdb_jump_in = 1'b0;
    cdb_next_pc_in = '0;
    mTail = 4'd1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    #1;

    // Reset state.
    checkOutput("rstFreePos", {28'd0, rob_free_pos_out}, 32'd1);
    checkOutput("rstFull", {31'd0, rob_full_out}, 32'd0);
    checkOutput("rstCommitEn", {31'd0, commit_to_regfile_en_out}, 32'd0);
    checkOutput("rstLsbEn", {31'd0, commit_to_lsb_en_out}, 32'd0);
    checkOutput("rstClear", {31'd0, clear_branch_out}, 32'd0);
    checkOutput("rstQuery1Ready", {31'd0, rob_query1_ready_out}, 32'd0);
    checkOutput("query0Ready", {31'd0, rob_query2_ready_out}, 32'd0);
    checkOutput("query0Res", rob_query2_res_out, 32'd0);

    // Three issues: tags 1, 2, 3.
    for (int i = 0; i < 3; i++) issueOp(6'(i + 1), 5'(i + 1), 1'b0, 1'b1);
    checkOutput("freePosAfter3", {28'd0, rob_free_pos_out}, 32'd4);

    // Global enable low: issue has no effect.
    rdy_in = 1'b0;
    issueOp(6'd9, 5'd9, 1'b0, 1'b0);
    rdy_in = 1'b1;
    checkOutput("rdyHoldFreePos", {28'd0, rob_free_pos_out}, 32'd4);

    // Fill to 15 entries; tag 7 is a store.
    for (int i = 3; i < 15; i++) issueOp((i == 6) ? 6'd17 : 6'((i % 10) + 1), 5'(i + 1), 1'b0, 1'b1);
    checkOutput("fullAt15", {31'd0, rob_full_out}, 32'd1);
    checkOutput("freePosWrap", {28'd0, rob_free_pos_out}, 32'd1);
    issueOp(6'd3, 5'd30, 1'b0, 1'b0);
    checkOutput("fullIgnoresIssue", {28'd0, rob_free_pos_out}, 32'd1);
    checkOutput("stillFull", {31'd0, rob_full_out}, 32'd1);

    // Out-of-order results retire in order.
    cdbOp(4'd2, 32'hAB, 1'b0, 32'd0);
    checkOutput("noEarlyCommit", {31'd0, commit_to_regfile_en_out}, 32'd0);
    tick();
    checkOutput("noCommitPos2", {31'd0, commit_to_regfile_en_out}, 32'd0);
    cdbOp(4'd1, 32'h11, 1'b0, 32'd0);
    repeat (3) tick();
    checkOutput("notFullAfter2", {31'd0, rob_full_out}, 32'd0);
    issueOp(6'd4, 5'd20, 1'b0, 1'b1);
    issueOp(6'd5, 5'd21, 1'b0, 1'b1);
    checkOutput("refull", {31'd0, rob_full_out}, 32'd1);

    // Same-cycle bypass on query 1; query 2 entry is pending.
    rob_query1_pos_in = 4'd5;
    rob_query2_pos_in = 4'd6;
    cdb_en_in = 1'b1;
    cdb_rob_pos_in = 4'd5;
    cdb_res_in = 32'h1234;
    cdb_jump_in = 1'b0;
    cdb_next_pc_in = 32'd0;
    #1;
    checkOutput("bypassReady", {31'd0, rob_query1_ready_out}, 32'd1);
    checkOutput("bypassRes", rob_query1_res_out, 32'h1234);
    checkOutput("pendingReady", {31'd0, rob_query2_ready_out}, 32'd0);
    expRes[5] = 32'h1234;
    expMisp[5] = 1'b0;
    tick();
    cdb_en_in = 1'b0;
    checkOutput("storedReady", {31'd0, rob_query1_ready_out}, 32'd1);
    checkOutput("storedRes", rob_query1_res_out, 32'h1234);

    // Resolve everything else and drain.
    foreach (cdbOrder[k]) cdbOp(4'(cdbOrder[k]), 32'h500 + cdbOrder[k], 1'b0, 32'd0);
    waitDrain(40);
    checkOutput("emptyFreePos", {28'd0, rob_free_pos_out}, 32'd3);

    // Mispredicted branch at head flushes; issue in the flush cycle is dropped.
    issueOp(6'd8, 5'd1, 1'b0, 1'b1);
    issueOp(6'd9, 5'd2, 1'b0, 1'b1);
    cdbOp(4'd3, 32'h2000, 1'b1, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (clear_branch_out === 1'b1) seen = 1'b1;
      else tick();
    end
    checkOutput("clearSeen", {31'd0, seen}, 32'd1);
    checkOutput("flushPc", clear_branch_pc_out, 32'h100);
    checkOutput("flushFreePos", {28'd0, rob_free_pos_out}, 32'd1);
    checkOutput("flushFull", {31'd0, rob_full_out}, 32'd0);
    mTail = 4'd1;
    issueOp(6'd2, 5'd3, 1'b0, 1'b0);
    checkOutput("clearOneCycle", {31'd0, clear_branch_out}, 32'd0);
    checkOutput("clearIssueDropped", {28'd0, rob_free_pos_out}, 32'd1);

    // Store retirement.
    issueOp(6'd16, 5'd0, 1'b0, 1'b1);
    cdbOp(4'd1, 32'h55, 1'b0, 32'd0);
    waitDrain(10);

    // Asynchronous reset while a commit pulse is high.
    issueOp(6'd3, 5'd6, 1'b0, 1'b1);
    issueOp(6'd4, 5'd7, 1'b0, 1'b1);
    cdbOp(4'd2, 32'h66, 1'b0, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (commit_to_regfile_en_out === 1'b1) seen = 1'b1;
      else tick();
    end
    checkOutput("preResetCommit", {31'd0, seen}, 32'd1);
    #1 rst_in = 1'b1;
    #1;
    checkOutput("asyncRstCommit", {31'd0, commit_to_regfile_en_out}, 32'd0);
    checkOutput("asyncRstRes", commit_to_regfile_res_out, 32'd0);
    checkOutput("asyncRstFreePos", {28'd0, rob_free_pos_out}, 32'd1);
    checkOutput("asyncRstClear", {31'd0, clear_branch_out}, 32'd0);
    expQ.delete();
    mTail = 4'd1;
    tick();
    rst_in = 1'b0;
    rob_query1_pos_in = 4'd3;
    #1;
    checkOutput("postRstQuery", {31'd0, rob_query1_ready_out}, 32'd0);
    checkOutput("postRstFull", {31'd0, rob_full_out}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the Tomasulo core. It sits between issue/CDB and the register file. It hands out ROB positions at issue and captures results from the CDB. It retires the head entry to the register file (and signals store commit to the LSB) in program order, and raises the branch-clear flush on a mispredicted branch. Position 0 is reserved to mean "no tag", matching the register-file tag convention, so usable positions are 1..15.

## Interface
- ROBSize, 16: physical slots; slot 0 is never allocated.
- Widths `ROBIdxWidth` (4), `WordWidth` (32), `RegIdxWidth` (5) and `InstrIdWidth` come from config.vh.

Ports:
- clk_in  in  1  clock; all state changes on its rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global enable; when 0 all state and registered outputs hold.
- rob_full_out  out  1  combinational, (count == 15).
- rob_free_pos_out  out  ROBIdxWidth  combinational tail position, used as the tag for the next issue.
- issue_to_rob_en_in  in  1  allocate the tail entry.
- issue_to_rob_instr_id_in  in  InstrIdWidth  instruction id.
- issue_to_rob_rd_in  in  RegIdxWidth  destination register.
- issue_to_rob_pc_in  in  WordWidth  instruction PC.
- issue_to_rob_pred_jump_in  in  1  predicted taken.
- rob_query1_pos_in / rob_query2_pos_in  in  ROBIdxWidth  operand tags to look up.
- rob_query1_ready_out / rob_query2_ready_out  out  1  combinational: the entry has a result.
- rob_query1_res_out / rob_query2_res_out  out  WordWidth  that result.
- cdb_en_in  in  1  result broadcast.
- cdb_rob_pos_in  in  ROBIdxWidth  producing entry.
- cdb_res_in  in  WordWidth  result value.
- cdb_jump_in  in  1  actual taken.
- cdb_next_pc_in  in  WordWidth  actual next PC.
- commit_to_regfile_en_out  out  1  registered one-cycle commit pulse.
- commit_to_regfile_instr_id_out  out  InstrIdWidth  committed instruction id.
- commit_to_regfile_rd_out  out  RegIdxWidth  committed destination.
- commit_to_regfile_rob_pos_out  out  ROBIdxWidth  committed position.
- commit_to_regfile_res_out  out  WordWidth  committed result.
- commit_to_lsb_en_out  out  1  registered pulse; head was a store.
- commit_to_lsb_rob_pos_out  out  ROBIdxWidth  position of that store.
- clear_branch_out  out  1  registered one-cycle flush.
- clear_branch_pc_out  out  WordWidth  redirect PC.

## Operation
- Per-entry state: valid, ready, instr_id, rd, pc, pred_jump, res, mispredict, next_pc. Pointers head and tail reset to 1; count resets to 0.
- Wrap-around: the successor of 15 is 1. Position 0 is never produced.
- Issue: when issue_to_rob_en_in=1 and not full, write the entry at tail with valid=1 and ready=0, then advance tail. Issue while full is ignored.
- CDB: when cdb_en_in=1 and the target entry is valid:
  - set ready=1 and res=cdb_res_in;
  - set mispredict=(cdb_jump_in != pred_jump) and next_pc=cdb_next_pc_in.
  - A CDB write to an invalid entry is ignored.
- Query returns ready=1 if the entry is ready, or if cdb_en_in=1 with cdb_rob_pos_in equal to the query position (same-cycle bypass, res=cdb_res_in).
  - Query position 0 returns ready=0 and res=0.
- Commit: if count>0 and the head is ready, retire at most one entry per cycle. On the next edge:
  - commit_to_regfile_* carries the entry's fields. Filtering by instr_id and rd is the register file's responsibility.
  - commit_to_lsb_en_out=1 if instr_id is a store.
  - The head advances and the entry is invalidated.
- Mispredict: if the committing entry has mispredict=1:
  - the same edge also sets clear_branch_out=1 and clear_branch_pc_out=next_pc;
  - all valid bits are cleared, head=tail=1, count=0.
  - The regfile commit for that entry is still emitted, so links are written.
- While clear_branch_out=1, issue and CDB inputs are ignored for that cycle.
- count update rules:
  - simultaneous issue and commit leave count unchanged;
  - issue and commit in the same cycle as a flush: the flush wins and any issue is dropped.
- Reset mid-operation: all state and outputs return to their reset values immediately.

## Timing
- Reset values: every registered output is 0. rob_free_pos_out=1, rob_full_out=0, query ready=0.
- Issue at edge t: the entry is valid from t+1, and rob_free_pos_out shows the next slot after t.
- CDB at cycle t: visible through the bypass in cycle t and stored from t+1. The earliest commit pulse is high after edge t+1.
- Commit outputs are one-cycle pulses; back-to-back commits produce consecutive pulses.
- rdy_in=0: no pointer, entry or output register changes.

## Structure
- config.vh holds `ROBIdxWidth`, `ROBSize`, the store instr_id range and the existing word, register and id widths.
- Single module with no sub-module. A local function computes the wrapping successor (15→1).

## Test plan
- Reset, then issue 3 entries → tags 1,2,3 issued; rob_free_pos_out=4; count=3.
- Fill 15 entries → rob_full_out=1; a 16th issue is ignored. Commit one → the next issue gets tag 1 (wrap past 0).
- CDB pos 2 res 0xAB, then CDB pos 1 → commit pulses carry pos 1 then pos 2 in order; pos 2 does not commit before pos 1.
- Query pos 5 in the same cycle as CDB pos 5 res 0x1234 → query ready=1, res=0x1234 combinationally.
- Branch at head with pred=0, CDB jump=1, next_pc=0x100 → clear_branch_out=1 with pc 0x100 for one cycle; count=0, free_pos=1. An issue in the clear cycle is dropped.
- Store at head ready → commit_to_lsb_en_out=1 with its pos. Assert rst_in mid-stream → all outputs 0 asynchronously.
